// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execute stage: opcodes, FSM states and
// the iteration count used by the sequential multiplier.
package alu_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_AW    = 3;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_MOV = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2,
    ST_WB   = 2'd3
  } state_t;

  // One shift-add iteration per multiplier bit.
  function automatic int mul_iters(input int width);
    return width;
  endfunction

endpackage

// File: rtl/seq_multiplier.sv
// Iterative unsigned shift-add multiplier; one multiplier bit per step.
module seq_multiplier
  import alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 step,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   product,
  output logic                 last
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      count;

  // product is the accumulator value after the current step, so the caller
  // can capture the final result on the same edge as the last iteration.
  assign product = acc + (mplier[0] ? mcand : '0);
  assign last    = (count == CW'(mul_iters(WIDTH) - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      count  <= '0;
    end else if (load) begin
      mcand  <= {{WIDTH{1'b0}}, a};
      acc    <= '0;
      mplier <= b;
      count  <= '0;
    end else if (step) begin
      acc    <= product;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + 1'b1;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Multi-cycle execute stage: latches operands on start, runs one ALU or
// iterative MUL operation and presents a write-back triple for the regfile.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int AW    = DEF_AW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [AW-1:0]    dest,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic [AW-1:0]    wa3,
  output logic             we3,
  output logic [WIDTH-1:0] wd3
);

  state_t state, state_next;

  logic [2:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [AW-1:0]      dest_q;

  logic [WIDTH-1:0]   alu_res;
  logic               alu_carry;
  logic               mul_load, mul_step, mul_last;
  logic [2*WIDTH-1:0] mul_product;
  logic               wb_load;
  logic [WIDTH-1:0]   wb_res;
  logic               wb_carry;

  seq_multiplier #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .load    (mul_load),
    .step    (mul_step),
    .a       (a_q),
    .b       (b_q),
    .product (mul_product),
    .last    (mul_last)
  );

  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    case (op_q)
      OP_ADD: {alu_carry, alu_res} = {1'b0, a_q} + {1'b0, b_q};
      OP_SUB: begin
        alu_res   = a_q - b_q;
        alu_carry = (a_q < b_q);
      end
      OP_AND: alu_res = a_q & b_q;
      OP_OR:  alu_res = a_q | b_q;
      OP_XOR: alu_res = a_q ^ b_q;
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      OP_MOV: alu_res = b_q;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_next = state;
    mul_load   = 1'b0;
    mul_step   = 1'b0;
    wb_load    = 1'b0;
    wb_res     = alu_res;
    wb_carry   = alu_carry;
    case (state)
      ST_IDLE: if (start) state_next = ST_EXEC;
      ST_EXEC: begin
        if (op_q == OP_MUL) begin
          mul_load   = 1'b1;
          state_next = ST_MUL;
        end else begin
          wb_load    = 1'b1;
          state_next = ST_WB;
        end
      end
      ST_MUL: begin
        mul_step = 1'b1;
        if (mul_last) begin
          wb_load    = 1'b1;
          wb_res     = mul_product[WIDTH-1:0];
          wb_carry   = |mul_product[2*WIDTH-1:WIDTH];
          state_next = ST_WB;
        end
      end
      ST_WB:   state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Result, flags and write address only change on entry to WB and are
  // otherwise held, so the regfile sees stable data through IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      dest_q <= '0;
      result <= '0;
      zero   <= 1'b0;
      carry  <= 1'b0;
      wa3    <= '0;
    end else begin
      state <= state_next;
      if (state == ST_IDLE && start) begin
        op_q   <= op;
        a_q    <= src_a;
        b_q    <= src_b;
        dest_q <= dest;
      end
      if (wb_load) begin
        result <= wb_res;
        zero   <= (wb_res == '0);
        carry  <= wb_carry;
        wa3    <= dest_q;
      end
    end
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_WB);
  assign we3  = done;
  assign wd3  = result;

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Multi-cycle execute stage that sits directly downstream of register_file.
- Consumes the two read ports (rd1, rd2) as operands and performs one ALU operation per start request.
- Produces a write-back triple (wa3, we3, wd3) that feeds straight back into register_file.
- Simple ops finish in 2 cycles. MUL uses an iterative shift-add over WIDTH cycles; the unit reports busy/done to the controlling sequencer.

Parameters:
- WIDTH, 8, data width of operands, result and write-back data.
- AW, 3, register address width (8 registers).

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-high; clears all state and outputs.
- start  in  1  request; sampled only in IDLE.
- op  in  3  operation code, latched with start.
- src_a  in  WIDTH  operand A (register_file rd1), latched with start.
- src_b  in  WIDTH  operand B (register_file rd2), latched with start.
- dest  in  AW  destination register, latched with start.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse in WB.
- result  out  WIDTH  last completed result; held until the next WB.
- zero  out  1  result == 0, updated in WB.
- carry  out  1  carry/borrow/overflow flag, updated in WB.
- wa3  out  AW  write address to register_file.
- we3  out  1  write enable to register_file; equals done.
- wd3  out  WIDTH  write data to register_file; equals result.

Behaviour:
- Reset: state=IDLE; busy, done, we3, zero, carry = 0; result, wd3, wa3 = 0. Reset mid-operation aborts it: no WB and no we3 pulse.
- Opcodes:
  - 000 ADD: A+B; carry = bit WIDTH of the sum.
  - 001 SUB: A-B mod 2^WIDTH; carry = 1 iff A<B unsigned (borrow).
  - 010 AND, 011 OR, 100 XOR: carry=0.
  - 101 SLT: result = 1 if A<B signed, else 0; carry=0.
  - 110 MUL: low WIDTH bits of A*B unsigned; carry = 1 iff the upper WIDTH bits are nonzero.
  - 111 MOV: result = B; carry=0.
- FSM states: IDLE, EXEC, MUL, WB.
  - IDLE: on start=1, latch op/src_a/src_b/dest and go to EXEC.
  - EXEC, non-MUL op: compute, register result/flags, go to WB.
  - EXEC, MUL op: load multiplicand=A, multiplier=B, accumulator=0, counter=0, go to MUL.
  - MUL: each cycle, if multiplier LSB=1 then acc += multiplicand (2*WIDTH-bit acc); multiplicand <<= 1; multiplier >>= 1; counter++. After WIDTH iterations, register result/flags and go to WB.
  - WB: done=1, we3=1, wa3=latched dest, wd3=result; next state IDLE.
- Latency, with start sampled at edge N:
  - Non-MUL: done high during the cycle after edge N+2.
  - MUL: done high during the cycle after edge N+2+WIDTH (N+10 for WIDTH=8).
  - Throughput: a new start is accepted in the IDLE cycle after WB, i.e. minimum 3 cycles per simple op.
- start while busy is ignored: not queued, no error.
- Operands are latched at acceptance; later changes on src_a/src_b/dest have no effect on the operation in flight.
- Outputs are decoded from registers only; there is no combinational path from inputs to outputs.
- dest may be any register, including 0; register_file semantics apply.
- Flags and result persist through IDLE until the next WB.

Decomposition:
- Package alu_pkg holds:
  - op code constants OP_ADD..OP_MOV (3-bit);
  - state encoding ST_IDLE, ST_EXEC, ST_MUL, ST_WB;
  - the MUL iteration count derived from WIDTH.
- One sub-module, seq_multiplier: handles load, shift-add iteration and the final product. It takes WIDTH and exposes load, step, product[2*WIDTH-1:0] and last.
- The FSM and the combinational ALU stay in alu_exec_unit.

Test Plan:
- Reset then idle → busy=0, done=0, we3=0, result=0. Assert rst mid-MUL at cycle 4 → state IDLE, no we3 pulse.
- ADD A=8'hF0, B=8'h20, dest=3 → 2 cycles after start: result=8'h10, carry=1, zero=0, we3=1, wa3=3, wd3=8'h10 for exactly 1 cycle.
- SUB A=5, B=5 → result=0, zero=1, carry=0. SUB A=3, B=5 → result=8'hFE, carry=1.
- SLT A=8'hFF (-1), B=8'h01 → result=1; SLT A=8'h01, B=8'hFF → result=0.
- MUL A=8'd12, B=8'd11 → done exactly 10 cycles after start, result=8'd132, carry=0. MUL A=8'd20, B=8'd20 → result=8'h90, carry=1.
- Start pulsed every cycle during a MUL with operands changing → only the first request executes, one done, wd3 matches the first operands; the next start is accepted in the cycle after WB.
